// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared register-file types, arbiter state and default sizing
package reg_write_arbiter_pkg;

    typedef logic        Bit_t;
    typedef logic [4:0]  Reg_addr_t;
    typedef logic [31:0] Reg_data_t;

    typedef enum logic {NORMAL, DRAIN} Warb_state_t;

    localparam int DEF_FIFO_DEPTH   = 2;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/reg_write_arbiter_lu_result_fifo.sv
// lu_result_fifo: long-latency result buffer with per-entry valid, address cancel and busy lookup
module lu_result_fifo
    import reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_valid,
    input  Reg_addr_t     push_addr,
    input  Reg_data_t     push_data,
    input  logic          pop,
    input  logic          cancel,
    input  Reg_addr_t     cancel_addr,
    input  Reg_addr_t     query_addr_1,
    input  Reg_addr_t     query_addr_2,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output Reg_addr_t     head_addr,
    output Reg_data_t     head_data,
    output logic          busy_1,
    output logic          busy_2
);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DEPTH-1:0] vld;
    Reg_addr_t        addr_q [DEPTH];
    Reg_data_t        data_q [DEPTH];

    // Pointers, occupancy and valid bits; popped slots are cleared so vld alone marks live entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (cancel && addr_q[i] == cancel_addr) vld[i] <= 1'b0;
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (push) begin
                vld[wr_ptr] <= push_valid;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; it is only observed through vld
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Head view and associative busy lookup over stored valid entries
    always_comb begin
        head_valid = vld[rd_ptr];
        head_addr  = addr_q[rd_ptr];
        head_data  = data_q[rd_ptr];
        busy_1     = 1'b0;
        busy_2     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_1 = busy_1 | (vld[i] && addr_q[i] == query_addr_1 && query_addr_1 != '0);
            busy_2 = busy_2 | (vld[i] && addr_q[i] == query_addr_2 && query_addr_2 != '0);
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between pipeline writeback and a buffered long-latency unit
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic      clk,
    input  logic      rst,
    input  Bit_t      wb_valid,
    input  Reg_addr_t wb_addr,
    input  Reg_data_t wb_data,
    input  Bit_t      lu_valid,
    output Bit_t      lu_ready,
    input  Reg_addr_t lu_addr,
    input  Reg_data_t lu_data,
    output Bit_t      stall_req,
    input  Reg_addr_t query_addr_1,
    input  Reg_addr_t query_addr_2,
    output Bit_t      query_busy_1,
    output Bit_t      query_busy_2,
    output Bit_t      write_enable,
    output Reg_addr_t write_addr,
    output Reg_data_t write_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    Warb_state_t   state, state_next;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] fifo_count;
    logic          head_valid, head_grant, wb_grant, pop, push, push_valid;
    Reg_addr_t     head_addr;
    Reg_data_t     head_data;

    lu_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_valid   (push_valid),
        .push_addr    (lu_addr),
        .push_data    (lu_data),
        .pop          (pop),
        .cancel       (wb_grant),
        .cancel_addr  (wb_addr),
        .query_addr_1 (query_addr_1),
        .query_addr_2 (query_addr_2),
        .count        (fifo_count),
        .head_valid   (head_valid),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .busy_1       (query_busy_1),
        .busy_2       (query_busy_2)
    );

    // Grant selection, FIFO handshake and next state; DRAIN ignores WB and forces the head out
    always_comb begin
        wb_grant   = state == NORMAL && wb_valid && wb_addr != '0;
        head_grant = head_valid && (state == DRAIN || !wb_grant);
        pop        = fifo_count != '0 && (!head_valid || head_grant);
        lu_ready   = fifo_count < CW'(FIFO_DEPTH);
        push       = lu_valid && lu_ready;
        push_valid = lu_addr != '0 && !(wb_grant && wb_addr == lu_addr);
        stall_req  = state == DRAIN;
        state_next = state == DRAIN ? NORMAL :
                     (starve_cnt >= SW'(STARVE_LIMIT) && head_valid && !head_grant) ? DRAIN : NORMAL;
    end

    // State register and starvation counter, saturating at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (pop)
                starve_cnt <= '0;
            else if (state == NORMAL && head_valid && !head_grant && starve_cnt < SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= wb_grant || head_grant;
            write_addr   <= head_grant ? head_addr : wb_addr;
            write_data   <= head_grant ? head_data : wb_data;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench for the register write-port arbiter
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    Bit_t      wb_valid = 1'b0, lu_valid = 1'b0;
    Reg_addr_t wb_addr = '0, lu_addr = '0, query_addr_1 = '0, query_addr_2 = '0;
    Reg_data_t wb_data = '0, lu_data = '0;
    Bit_t      lu_ready, stall_req, query_busy_1, query_busy_2, write_enable;
    Reg_addr_t write_addr;
    Reg_data_t write_data;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .stall_req    (stall_req),
        .query_addr_1 (query_addr_1),
        .query_addr_2 (query_addr_2),
        .query_busy_1 (query_busy_1),
        .query_busy_2 (query_busy_2),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        sb.push_back({a, d});
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v;
        lu_addr  = a;
        lu_data  = d;
    endtask

    // Every observed write must match the oldest expected one
    always @(negedge clk) begin
        wr_t e;
        if (write_enable) begin
            if (sb.size() == 0)
                check("unexpected_write", {27'd0, write_addr, write_data}, 64'd0);
            else begin
                e = sb.pop_front();
                check("wr_addr", 64'(write_addr), 64'(e.a));
                check("wr_data", 64'(write_data), 64'(e.d));
            end
        end
    end

    initial begin
        int rdy_exp[5] = '{1, 1, 0, 0, 1};
        #1 rst = 1'b0;
        query_addr_1 = 5'd5;
        #11;
        check("rst_we", 64'(write_enable), 64'd0);
        check("rst_wa", 64'(write_addr), 64'd0);
        check("rst_wd", 64'(write_data), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_ready", 64'(lu_ready), 64'd1);
        check("rst_busy", 64'(query_busy_1), 64'd0);
        @(negedge clk) rst = 1'b1;

        // isolated long-latency write
        cyc();
        drive_lu(1'b1, 5'd5, 32'h1234);
        exp_wr(5'd5, 32'h1234);
        #1 check("iso_busy_enq", 64'(query_busy_1), 64'd0);
        cyc();
        lu_valid = 1'b0;
        #1 check("iso_busy_stored", 64'(query_busy_1), 64'd1);
        cyc();
        check("iso_we", 64'(write_enable), 64'd1);
        check("iso_wa", 64'(write_addr), 64'd5);
        idle(3);

        // writeback priority with forced drain
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("wbp_stall", 64'(stall_req), 64'(i == 6));
            if (i == 6) begin
                wb_valid = 1'b0;
                exp_wr(5'd7, 32'hB);
            end else begin
                drive_wb(1'b1, 5'd3, 32'(32'hA0 + i));
                exp_wr(5'd3, 32'(32'hA0 + i));
            end
            drive_lu(i == 0, 5'd7, 32'hB);
        end
        cyc();
        idle(4);

        // full FIFO back-pressure
        for (int i = 0; i < 5; i++) begin
            cyc();
            drive_wb(i < 3, 5'd3, 32'(32'hC0 + i));
            if (i < 3) exp_wr(5'd3, 32'(32'hC0 + i));
            if (i == 2) begin
                exp_wr(5'd20, 32'h220);
                exp_wr(5'd21, 32'h221);
            end
            if (i == 4) exp_wr(5'd22, 32'h222);
            drive_lu(1'b1, i < 2 ? 5'(20 + i) : 5'd22, i < 2 ? 32'(32'h220 + i) : 32'h222);
            #1 check("full_ready", 64'(lu_ready), 64'(rdy_exp[i]));
        end
        cyc();
        idle(4);

        // WAW cancellation of a queued entry
        query_addr_2 = 5'd9;
        cyc();
        drive_lu(1'b1, 5'd9, 32'h1);
        #1 check("waw_busy_enq", 64'(query_busy_2), 64'd0);
        cyc();
        lu_valid = 1'b0;
        drive_wb(1'b1, 5'd9, 32'h2);
        exp_wr(5'd9, 32'h2);
        #1 check("waw_busy_q", 64'(query_busy_2), 64'd1);
        cyc();
        wb_valid = 1'b0;
        #1 check("waw_busy_drop", 64'(query_busy_2), 64'd0);
        idle(4);

        // same-cycle WB and LU to one register: LU entry enqueued dead
        query_addr_1 = 5'd12;
        cyc();
        drive_wb(1'b1, 5'd12, 32'h5);
        drive_lu(1'b1, 5'd12, 32'h6);
        exp_wr(5'd12, 32'h5);
        cyc();
        idle(0);
        #1 check("same_busy", 64'(query_busy_1), 64'd0);
        idle(4);

        // zero register requests
        query_addr_1 = 5'd0;
        cyc();
        drive_wb(1'b1, 5'd0, 32'hDEAD);
        drive_lu(1'b1, 5'd0, 32'hBEEF);
        cyc();
        idle(0);
        #1 check("zero_busy", 64'(query_busy_1), 64'd0);
        cyc();
        check("zero_we", 64'(write_enable), 64'd0);
        idle(3);

        // reset while draining with two entries queued
        query_addr_1 = 5'd11;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("rm_stall", 64'(stall_req), 64'(i == 6));
            drive_wb(i < 6, 5'd3, 32'(32'hD0 + i));
            if (i < 5) exp_wr(5'd3, 32'(32'hD0 + i));
            drive_lu(i < 2, 5'(10 + i), 32'(32'h300 + i));
        end
        #1 check("rm_busy_pre", 64'(query_busy_1), 64'd1);
        rst = 1'b0;
        #1;
        check("rm_we", 64'(write_enable), 64'd0);
        check("rm_wa", 64'(write_addr), 64'd0);
        check("rm_wd", 64'(write_data), 64'd0);
        check("rm_stall_rst", 64'(stall_req), 64'd0);
        check("rm_ready", 64'(lu_ready), 64'd1);
        check("rm_busy", 64'(query_busy_1), 64'd0);
        cyc();
        rst = 1'b1;
        idle(8);
        check("rm_busy_post", 64'(query_busy_1), 64'd0);
        check("rm_stall_post", 64'(stall_req), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency unit (multiplier/divider result path). Pipeline writes always win; long-latency results wait in a small FIFO and drain into idle write slots. A starvation counter forces a one-cycle pipeline stall to drain the FIFO. Busy-query outputs let the decode stage detect pending writes. The block sits directly in front of `registers`.

## Interface
- `FIFO_DEPTH`, 2: long-latency result buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: cycles a valid FIFO head may be refused before forced drain.

- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.
- `wb_valid` in `Bit_t`: pipeline writeback request.
- `wb_addr` in `Reg_addr_t`: pipeline destination register.
- `wb_data` in `Reg_data_t`: pipeline write data.
- `lu_valid` in `Bit_t`: long-latency result valid.
- `lu_ready` out `Bit_t`: FIFO can accept.
- `lu_addr` in `Reg_addr_t`: long-latency destination register.
- `lu_data` in `Reg_data_t`: long-latency result.
- `stall_req` out `Bit_t`: pipeline must freeze WB this cycle.
- `query_addr_1`, `query_addr_2` in `Reg_addr_t`: decode source registers.
- `query_busy_1`, `query_busy_2` out `Bit_t`: register has a valid pending FIFO entry.
- `write_enable` out `Bit_t`, `write_addr` out `Reg_addr_t`, `write_data` out `Reg_data_t`: to the register file write port.

## Operation
- Accept: `lu_valid && lu_ready`. `lu_ready` = (count < FIFO_DEPTH), based on pre-pop count; a same-cycle pop does not free a slot.
- Each entry stores addr, data, and a valid bit. An accepted `lu_addr==0` is enqueued invalid.
- Cancellation (WAW): a granted WB write to address A clears the valid bit of every FIFO entry with addr A. If A equals an `lu_addr` accepted the same cycle, that entry is enqueued invalid; the pipeline write is younger.
- Invalid head: popped in any cycle without using the port; resets the starve counter.
- States:
  - NORMAL: grant WB if `wb_valid && wb_addr!=0`. Otherwise grant a valid FIFO head and pop it. Otherwise no write.
  - DRAIN: `stall_req=1`. Pipeline guarantees `wb_valid=0`; if violated, the WB request is ignored. Grant the valid head, pop it, return to NORMAL.
- Starve counter: increments each NORMAL cycle in which the head is valid but not granted; clears on head pop. When the counter reaches STARVE_LIMIT, the next state is DRAIN.
- `query_busy_n` is combinational over stored valid entries only; same-cycle enqueues are not included. Address 0 is never busy.
- `wb_addr==0` with `wb_valid`: no write, no cancellation.

## Timing
- Write outputs are registered: a grant in cycle t appears on `write_*` in cycle t+1.
- FIFO entry accepted in cycle t is grantable from cycle t+1 at earliest.
- `stall_req` is a Moore output of DRAIN. It asserts STARVE_LIMIT+1 cycles after the head first became valid and refused, and lasts exactly 1 cycle.
- Reset values: `write_enable=0`, `write_addr=0`, `write_data=0`, `stall_req=0`, FIFO empty (`lu_ready=1`, all `query_busy=0`), counter 0, state NORMAL.
- Reset mid-operation: pending entries are discarded and no write is issued. Upstream must reissue.

## Structure
- `Bit_t`, `Reg_addr_t`, `Reg_data_t` come from `defines.svh`. Add arbiter state enum `Warb_state_t` (NORMAL, DRAIN) and default STARVE_LIMIT/FIFO_DEPTH constants to the shared package.
- One sub-module: `lu_result_fifo` (storage, pointers, count, per-entry valid with associative cancel and busy lookup ports).

## Test plan
- Isolated LU: `lu` write r5=0x1234 with no WB → `write_enable=1`, addr 5, data 0x1234 two cycles after accept.
- WB priority: WB r3=0xA each cycle, LU r7=0xB accepted → r7 written only after `stall_req` pulse at cycle STARVE_LIMIT+1 (5); r3 writes continue otherwise.
- Full FIFO: three back-to-back `lu_valid` with depth 2 → third sees `lu_ready=0` until a pop; no entry lost or duplicated.
- WAW cancel: LU r9=0x1 queued, then WB r9=0x2 → r9 ends 0x2; LU entry popped without a write; `query_busy` for 9 drops the cycle after.
- Zero register: WB r0 and LU r0 requests → `write_enable` never asserts with addr 0.
- Reset mid-drain: assert `rst` low while in DRAIN with 2 entries → all outputs at reset values immediately; no write after release.
